// File: rtl/wb_burst_master_pkg.sv
// Shared constants and state encoding for the Wishbone burst master.
// Cycle-type tags follow the Wishbone B3 registered-feedback encoding.
package wb_burst_master_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/wb_ack_watchdog.sv
// Ack watchdog: counts stalled strobe cycles and flags expiry at TO_CYC.
// Compiled only when WB_BURST_MASTER_TIMEOUT_EN is defined.
`ifdef WB_BURST_MASTER_TIMEOUT_EN
module wb_ack_watchdog #(
    parameter int TO_CYC = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_expired
);

    localparam int CW = $clog2(TO_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TO_CYC - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (!i_run) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry fires in the TO_CYC-th waiting cycle so the abort lands on that edge.
    assign o_expired = i_run && (r_count == LIMIT);

endmodule
`endif

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst master with command, write-data and read-data streams.
// Optional ack timeout enabled by defining WB_BURST_MASTER_TIMEOUT_EN.
module wb_burst_master
    import wb_burst_master_pkg::*;
#(
    parameter int dw     = 32,
    parameter int aw     = 32,
    parameter int LW     = 4,
    parameter int TO_CYC = 256
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [aw-1:0] cmd_adr_i,
    input  logic [LW-1:0] cmd_len_i,
    input  logic          wdat_valid_i,
    output logic          wdat_ready_o,
    input  logic [dw-1:0] wdat_i,
    output logic          rdat_valid_o,
    input  logic          rdat_ready_i,
    output logic [dw-1:0] rdat_o,
    output logic          rdat_last_o,
    output logic          done_o,
    output logic          err_o,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic [1:0]    wb_bte_o,
    output logic [2:0]    wb_cti_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_we;
    logic          r_single;
    logic [aw-1:0] r_adr;
    logic [LW-1:0] r_cnt;
    logic [dw-1:0] r_rdat;
    logic          r_rvalid;
    logic          r_rlast;
    logic          r_done;
    logic          r_err;

    logic          w_burst;
    logic          w_accept;
    logic          w_stb;
    logic          w_abort;
    logic          w_ack;
    logic          w_last;
    logic          w_timeout;

    assign w_burst  = (r_state == BURST);
    assign w_accept = !w_burst && cmd_valid_i;
    assign w_last   = (r_cnt == '0);

    // Reads hold off the strobe while the single output register is still occupied.
    assign w_stb   = w_burst && (r_we ? wdat_valid_i : (!r_rvalid || rdat_ready_i));
    assign w_abort = w_stb && (wb_err_i || wb_rty_i || w_timeout);
    assign w_ack   = w_stb && wb_ack_i && !w_abort;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    wb_ack_watchdog #(
        .TO_CYC (TO_CYC)
    ) u_watchdog (
        .i_clk     (wb_clk_i),
        .i_rst_n   (wb_rst_i),
        .i_run     (w_stb && !wb_ack_i),
        .o_expired (w_timeout)
    );
`else
    // Without the watchdog the master waits for the slave indefinitely.
    assign w_timeout = (TO_CYC < 0);
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready_o = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        wb_sel_o    = 4'h0;
        wb_we_o     = 1'b0;
        wb_adr_o    = '0;
        wb_dat_o    = '0;
        wb_cti_o    = CTI_CLASSIC;
        wb_bte_o    = BTE_LINEAR;
        case (r_state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = w_stb;
                wb_sel_o = 4'hf;
                wb_we_o  = r_we;
                wb_adr_o = r_adr;
                wb_dat_o = r_we ? wdat_i : '0;
                if (r_single) begin
                    wb_cti_o = CTI_CLASSIC;
                end else begin
                    wb_cti_o = w_last ? CTI_EOB : CTI_INCR;
                end
                if (w_abort || (w_ack && w_last)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_we     <= 1'b0;
            r_single <= 1'b0;
            r_adr    <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_we     <= cmd_we_i;
            r_single <= (cmd_len_i == '0);
            r_adr    <= cmd_adr_i;
            r_cnt    <= cmd_len_i;
        end else if (w_ack) begin
            r_adr    <= r_adr + 1'b1;
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    // A fresh ack refills the output register even when the consumer drains it the same cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_rdat   <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
        end else if (w_ack && !r_we) begin
            r_rdat   <= wb_dat_i;
            r_rvalid <= 1'b1;
            r_rlast  <= w_last;
        end else if (rdat_ready_i) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_ack && w_last;
            r_err  <= w_abort;
        end
    end

    assign wdat_ready_o = w_ack && r_we;
    assign rdat_o       = r_rdat;
    assign rdat_valid_o = r_rvalid;
    assign rdat_last_o  = r_rlast;
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule
